// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - OBI slave front-end for one SRAM bank with power-up/on-demand zero-fill
module sram_bank_ctrl #(
    parameter int unsigned NumWords   = 8192,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter bit          InitEnable = 1'b1,
    parameter int unsigned AddrWidth  = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    input  logic                 clear_i,
    output logic                 init_done_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic [3:0]           sram_be_o,
    input  logic [31:0]          sram_rdata_i
);

    typedef enum logic {StInit, StRun} state_e;

    localparam state_e               ResetState = InitEnable ? StInit : StRun;
    localparam logic [AddrWidth-1:0] LastWord   = AddrWidth'(NumWords - 1);
    localparam logic [32:0]          BankBytes  = 33'(NumWords) << 2;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  cnt_q, cnt_d;
    logic                  rvalid_q, err_q, rd_q;
    logic [31:0]           offset;
    logic                  in_range;
    logic                  clear_eff;

    // Comparing the full byte offset keeps addr_i[1:0] out of the decision
    // while still rejecting anything past the last word.
    assign offset    = addr_i - BaseAddr;
    assign in_range  = (addr_i >= BaseAddr) && ({1'b0, offset} < BankBytes);
    assign clear_eff = InitEnable & clear_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_o        = 1'b0;
        init_done_o  = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = we_i;
        sram_be_o    = be_i;
        sram_wdata_o = wdata_i;
        sram_addr_o  = offset[AddrWidth+1:2];
        case (state_q)
            StInit: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_be_o    = 4'hF;
                sram_wdata_o = '0;
                sram_addr_o  = cnt_q;
                if (cnt_q == LastWord) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + AddrWidth'(1);
                end
            end
            StRun: begin
                init_done_o = 1'b1;
                gnt_o       = req_i & ~clear_eff;
                sram_req_o  = gnt_o & in_range;
                if (clear_eff) begin
                    state_d = StInit;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ResetState;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt_o;
            err_q    <= gnt_o & ~in_range;
            rd_q     <= gnt_o & in_range & ~we_i;
        end
    end

    // Read data comes straight from the macro in the response cycle; writes
    // and errors return zero.
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rd_q ? sram_rdata_i : 32'h0;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - randomized and directed checks of sram_bank_ctrl against a word-array model
module tb_sram_bank_ctrl;

    localparam int          NW   = 8192;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        clear_i = 1'b0;
    logic        init_done_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [12:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata_i;

    always #5 clk_i = ~clk_i;

    sram_bank_ctrl #(
        .NumWords  (NW),
        .BaseAddr  (BASE),
        .InitEnable(1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .clear_i     (clear_i),
        .init_done_o (init_done_o),
        .sram_req_o  (sram_req_o),
        .sram_we_o   (sram_we_o),
        .sram_addr_o (sram_addr_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_be_o   (sram_be_o),
        .sram_rdata_i(sram_rdata_i)
    );

    // SRAM macro behaviour: byte-masked write, registered read.
    logic [31:0] sram_mem [NW];
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [NW];
    bit          running = 1'b0;
    bit          exp_rv = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle, starting and ending at a falling edge.
    task automatic bus_cycle(input logic r, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d, input logic c);
        logic        gnt_e, inr;
        logic [31:0] idx;
        logic [12:0] widx;
        chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
        if (exp_rv) begin
            chk("err", 32'(err_o), 32'(exp_err));
            chk("rdata", rdata_o, exp_rd);
        end
        req_i = r; we_i = w; addr_i = a; be_i = b; wdata_i = d; clear_i = c;
        #1;
        gnt_e = running && r && !c;
        idx   = (a - BASE) / 4;
        inr   = (a >= BASE) && (idx < NW);
        widx  = idx[12:0];
        chk("gnt", 32'(gnt_o), 32'(gnt_e));
        chk("init_done", 32'(init_done_o), 32'(running));
        if (gnt_e) begin
            chk("sram_req", 32'(sram_req_o), 32'(inr));
            if (inr) begin
                chk("sram_addr", 32'(sram_addr_o), 32'(widx));
                chk("sram_we", 32'(sram_we_o), 32'(w));
            end
        end
        exp_rv  = gnt_e;
        exp_err = gnt_e && !inr;
        exp_rd  = (gnt_e && inr && !w) ? model_mem[widx] : 32'h0;
        if (gnt_e && inr && w)
            for (int k = 0; k < 4; k++)
                if (b[k]) model_mem[widx][8*k +: 8] = d[8*k +: 8];
        if (running && c) running = 1'b0;
        @(negedge clk_i);
    endtask

    // Expects to be entered on the falling edge of the first fill cycle.
    task automatic run_init();
        int bad = 0;
        for (int i = 0; i < NW; i++) begin
            req_i = 1'($urandom); clear_i = 1'($urandom); addr_i = $urandom % 256;
            #1;
            if (!(sram_req_o && sram_we_o && sram_addr_o == 13'(i) && sram_wdata_o == 32'h0 &&
                  sram_be_o == 4'hF && !gnt_o && !init_done_o && !rvalid_o)) bad++;
            @(negedge clk_i);
        end
        req_i = 1'b0; clear_i = 1'b0;
        #1;
        chk("init_seq_bad_cycles", 32'(bad), 32'h0);
        chk("init_done_after_fill", 32'(init_done_o), 32'h1);
        running = 1'b1;
        exp_rv  = 1'b0;
        for (int i = 0; i < NW; i++) model_mem[i] = 32'h0;
    endtask

    initial begin
        int bad;
        int sel;
        logic [31:0] a;
        rst_ni = 1'b0;
        req_i  = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_init_done", 32'(init_done_o), 32'h0);
        chk("rst_sram_addr", 32'(sram_addr_o), 32'h0);

        // Interrupt the first fill at word 100.
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!(sram_req_o && sram_addr_o == 13'(i) && !gnt_o)) bad++;
            @(negedge clk_i);
        end
        #1;
        chk("pre_reset_bad", 32'(bad), 32'h0);
        chk("pre_reset_addr", 32'(sram_addr_o), 32'd100);
        rst_ni = 1'b0;
        #1;
        chk("mid_reset_addr", 32'(sram_addr_o), 32'h0);
        chk("mid_reset_gnt", 32'(gnt_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        run_init();

        // Full write/read, then partial byte-enable write.
        bus_cycle(1, 1, 32'h40, 4'hF, 32'hDEADBEEF, 0);
        bus_cycle(1, 0, 32'h40, 4'hF, 32'h0, 0);
        chk("read_40_literal", rdata_o, 32'hDEADBEEF);
        bus_cycle(1, 1, 32'h80, 4'b0101, 32'h11223344, 0);
        bus_cycle(1, 0, 32'h80, 4'hF, 32'h0, 0);
        chk("read_80_literal", rdata_o, 32'h00220044);
        bus_cycle(1, 0, BASE + 32'h8000, 4'hF, 32'h0, 0);
        chk("oor_rvalid_literal", 32'(rvalid_o), 32'h1);
        chk("oor_err_literal", 32'(err_o), 32'h1);
        chk("oor_rdata_literal", rdata_o, 32'h0);
        bus_cycle(0, 0, 32'h0, 4'h0, 32'h0, 0);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom % 8;
            if (sel < 5)      a = BASE + (($urandom % 32) * 4) + ($urandom % 4);
            else if (sel < 7) a = BASE + (($urandom % NW) * 4) + ($urandom % 4);
            else              a = $urandom | 32'h0000_8000;
            bus_cycle(($urandom % 4) != 0, 1'($urandom), a, 4'($urandom), $urandom, 0);
        end

        // Grant in cycle N, clear with a request in N+1.
        bus_cycle(1, 0, 32'h40, 4'hF, 32'h0, 0);
        bus_cycle(1, 0, 32'h80, 4'hF, 32'h0, 1);
        #1;
        chk("clear_init_done_low", 32'(init_done_o), 32'h0);
        chk("clear_no_rvalid", 32'(rvalid_o), 32'h0);
        run_init();

        for (int i = 0; i < 32; i++) bus_cycle(1, 0, BASE + 32'(i * 4), 4'hF, 32'h0, 0);
        bus_cycle(1, 0, 32'h40, 4'hF, 32'h0, 0);
        chk("refill_zero_literal", rdata_o, 32'h0);
        bus_cycle(0, 0, 32'h0, 4'h0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
